// File: rtl/rwt_axis_tag_escaper.sv
// rwt_axis_tag_escaper
// Converts a tagged AXIS stream (tdata + tuser tag) into a single in-band
// escaped stream. For each accepted beat D with tag T:
//   T != 0     -> ESCAPE, {zeros, T}
//   D == ESCAPE -> ESCAPE, ESCAPE
//   otherwise  -> D
// If both apply, the tag pair comes first, then the literal pair. Bypass mode
// passes D through raw with the tag dropped. Mode changes are taken only at
// packet boundaries.
//
// Ports:
//   clk, resetn          clock, async active-low reset (sync release)
//   bypass               pass-through request (sampled at packet boundary)
//   s_axis_*             tagged input stream (tdata, tuser, tlast, tvalid, tready)
//   m_axis_*             escaped output stream (tdata, tlast, tvalid, tready)
//   bypass_active        mode currently in effect
//   stat_beats/escapes/tags  accepted beats, literal pairs, tag pairs
//
// Build option: define RWT_ESC_STATS_EN to build the statistics counters;
// otherwise stat_* are tied to zero.
module rwt_axis_tag_escaper #(
  parameter int unsigned       DWIDTH = 32,
  parameter int unsigned       UWIDTH = 2,
  parameter logic [DWIDTH-1:0] ESCAPE = DWIDTH'(32'hAAAAAAAA),
  parameter int unsigned       CWIDTH = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              bypass,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic [UWIDTH-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              bypass_active,
  output logic [CWIDTH-1:0] stat_beats,
  output logic [CWIDTH-1:0] stat_escapes,
  output logic [CWIDTH-1:0] stat_tags
);

  localparam int unsigned ST_W = 3;

  // Parameter legality checks at elaboration
  if (DWIDTH < 8 || DWIDTH > 64) begin : g_bad_dwidth
    $fatal(1, "rwt_axis_tag_escaper: DWIDTH out of range");
  end
  if (UWIDTH < 1 || UWIDTH >= DWIDTH) begin : g_bad_uwidth
    $fatal(1, "rwt_axis_tag_escaper: UWIDTH out of range");
  end
  if (ESCAPE[DWIDTH-1] != 1'b1) begin : g_bad_escape
    $fatal(1, "rwt_axis_tag_escaper: ESCAPE MSB must be 1");
  end

  typedef enum logic [ST_W-1:0] {
    S_IDLE   = 3'd0,
    S_TAGESC = 3'd1,
    S_TAG    = 3'd2,
    S_LITESC = 3'd3,
    S_DATA   = 3'd4
  } state_t;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [UWIDTH-1:0] tag;
    logic              last;
  } beat_t;

  state_t            r_state;
  state_t            w_state_nxt;
  beat_t             r_hold;
  beat_t             w_in;
  logic [DWIDTH-1:0] r_tdata;
  logic [DWIDTH-1:0] w_tdata_nxt;
  logic              r_tlast;
  logic              w_tlast_nxt;
  logic              r_tvalid;
  logic              w_tvalid_nxt;
  logic              r_run;
  logic              r_bypass_active;
  logic              r_pkt_open;

  logic              w_ready;
  logic              w_accept;
  logic              w_adv;
  logic              w_boundary;
  logic              w_mode;
  logic              w_esc_tag;
  logic              w_esc_lit;
  state_t            w_first_state;
  logic [DWIDTH-1:0] w_first_word;
  logic              w_first_last;

  assign w_in = '{data: s_axis_tdata, tag: s_axis_tuser, last: s_axis_tlast};

  // r_run keeps tready low while reset is asserted and until the first edge after release
  assign w_ready  = r_run && ((r_state == S_IDLE) || ((r_state == S_DATA) && m_axis_tready));
  assign w_accept = s_axis_tvalid && w_ready;
  assign w_adv    = r_tvalid && m_axis_tready;

  // Mode may only change between packets
  assign w_boundary = r_run && (((r_state == S_IDLE) && !r_pkt_open) ||
                                ((r_state == S_DATA) && m_axis_tready && r_hold.last));
  assign w_mode     = w_boundary ? bypass : r_bypass_active;

  assign w_esc_tag = !w_mode && (s_axis_tuser != '0);
  assign w_esc_lit = !w_mode && (s_axis_tdata == ESCAPE);

  // First output word of a newly accepted beat
  always_comb begin
    w_first_state = S_DATA;
    w_first_word  = s_axis_tdata;
    w_first_last  = s_axis_tlast;
    if (w_esc_tag) begin
      w_first_state = S_TAGESC;
      w_first_word  = ESCAPE;
      w_first_last  = 1'b0;
    end else if (w_esc_lit) begin
      w_first_state = S_LITESC;
      w_first_word  = ESCAPE;
      w_first_last  = 1'b0;
    end
  end

  // State and registered output stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tdata  <= w_tdata_nxt;
      r_tlast  <= w_tlast_nxt;
      r_tvalid <= w_tvalid_nxt;
    end
  end

  // Next state and next output word; words advance only on output handshake
  always_comb begin
    w_state_nxt  = r_state;
    w_tdata_nxt  = r_tdata;
    w_tlast_nxt  = r_tlast;
    w_tvalid_nxt = r_tvalid;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = w_first_state;
          w_tdata_nxt  = w_first_word;
          w_tlast_nxt  = w_first_last;
          w_tvalid_nxt = 1'b1;
        end
      end
      S_TAGESC: begin
        if (w_adv) begin
          w_state_nxt = S_TAG;
          w_tdata_nxt = DWIDTH'(r_hold.tag);
          w_tlast_nxt = 1'b0;
        end
      end
      S_TAG: begin
        if (w_adv) begin
          if (r_hold.data == ESCAPE) begin
            w_state_nxt = S_LITESC;
            w_tdata_nxt = ESCAPE;
            w_tlast_nxt = 1'b0;
          end else begin
            w_state_nxt = S_DATA;
            w_tdata_nxt = r_hold.data;
            w_tlast_nxt = r_hold.last;
          end
        end
      end
      S_LITESC: begin
        if (w_adv) begin
          // Second escape of the pair equals the held data word
          w_state_nxt = S_DATA;
          w_tdata_nxt = r_hold.data;
          w_tlast_nxt = r_hold.last;
        end
      end
      S_DATA: begin
        if (w_adv) begin
          if (w_accept) begin
            w_state_nxt  = w_first_state;
            w_tdata_nxt  = w_first_word;
            w_tlast_nxt  = w_first_last;
            w_tvalid_nxt = 1'b1;
          end else begin
            w_state_nxt  = S_IDLE;
            w_tvalid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_tvalid_nxt = 1'b0;
      end
    endcase
  end

  // Held beat, packet tracking and mode register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold          <= '0;
      r_run           <= 1'b0;
      r_pkt_open      <= 1'b0;
      r_bypass_active <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_hold     <= w_in;
        r_pkt_open <= !s_axis_tlast;
      end
      if (w_boundary) begin
        r_bypass_active <= bypass;
      end
    end
  end

  assign s_axis_tready = w_ready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;
  assign bypass_active = r_bypass_active;

`ifdef RWT_ESC_STATS_EN
  logic [CWIDTH-1:0] r_stat_beats;
  logic [CWIDTH-1:0] r_stat_escapes;
  logic [CWIDTH-1:0] r_stat_tags;

  // Statistics, counted once per accepted beat, wrapping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_beats   <= '0;
      r_stat_escapes <= '0;
      r_stat_tags    <= '0;
    end else if (w_accept) begin
      r_stat_beats <= r_stat_beats + CWIDTH'(1);
      if (w_esc_lit) begin
        r_stat_escapes <= r_stat_escapes + CWIDTH'(1);
      end
      if (w_esc_tag) begin
        r_stat_tags <= r_stat_tags + CWIDTH'(1);
      end
    end
  end

  assign stat_beats   = r_stat_beats;
  assign stat_escapes = r_stat_escapes;
  assign stat_tags    = r_stat_tags;
`else
  assign stat_beats   = '0;
  assign stat_escapes = '0;
  assign stat_tags    = '0;
`endif

endmodule

// File: doc/rwt_axis_tag_escaper.md
Name: rwt_axis_tag_escaper

Overview:
- Streaming encoder that converts a tagged AXIS stream (data plus UWIDTH-bit tuser tag) into a single in-band escaped stream. This is the encoding consumed by the rwt escaped-stream file sinks and DMA paths.
- Generalises the fixed 32-bit/AAAAAAAA tagged-packet format in data width, tag width and escape word.
- Adds packet-boundary bypass and optional statistics.
- Sits between tag-producing DSP blocks and the DMA/FIFO.

Parameters:
- DWIDTH, 32: data width in bits; 8..64.
- UWIDTH, 2: tag width in bits; 1..DWIDTH-1.
- ESCAPE, 32'hAAAAAAAA: escape word, DWIDTH bits. Bit DWIDTH-1 must be 1; elaboration fatal otherwise.
- CWIDTH, 32: statistics counter width.

Ports:
- clk, in, 1: clock.
- resetn, in, 1: asynchronous active-low reset.
- bypass, in, 1: request pass-through mode (tag dropped, no escaping).
- s_axis_tdata, in, DWIDTH: input data.
- s_axis_tuser, in, UWIDTH: tag; non-zero means tag present on this beat.
- s_axis_tlast, in, 1: input end of packet.
- s_axis_tvalid, in, 1: input valid.
- s_axis_tready, out, 1: input ready.
- m_axis_tdata, out, DWIDTH: encoded data.
- m_axis_tlast, out, 1: encoded end of packet.
- m_axis_tvalid, out, 1: output valid.
- m_axis_tready, in, 1: output ready.
- bypass_active, out, 1: current mode in effect.
- stat_beats, out, CWIDTH: input beats accepted.
- stat_escapes, out, CWIDTH: literal-escape pairs emitted.
- stat_tags, out, CWIDTH: tag sequences emitted.

Behaviour:
- Reset (async assert, sync release): m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0 during reset, bypass_active=0, all stats=0, FSM=S_IDLE.
- Encoding per accepted input beat D with tag T, in output order:
  - T!=0: ESCAPE, then tag word {zeros, T} (MSB 0, so never equal to ESCAPE).
  - D==ESCAPE: ESCAPE, ESCAPE.
  - Otherwise: D.
  - Both apply: tag pair first, then literal pair (4 words total).
- m_axis_tlast=1 only on the last word emitted for an input beat with tlast=1.
- Bypass active: output word = D, tlast copied, tag ignored, no escaping.
- Registered output stage. An accepted beat appears on m_axis_tvalid the next cycle. No combinational path from m_axis_tready to s_axis_tready other than through the "final word consumed" term.
- s_axis_tready = (FSM in S_IDLE) OR (output word is the final word of its beat AND m_axis_tready). This gives full throughput (1 beat/cycle) for unescaped data.
- FSM states:
  - S_IDLE: no word held.
  - S_TAGESC: ESCAPE of a tag pair on the output.
  - S_TAG: tag word on the output.
  - S_LITESC: first ESCAPE of a literal pair.
  - S_DATA: final word of the beat (data or second ESCAPE).
  - Transitions advance only on m_axis_tvalid && m_axis_tready. Input beat fields are held in a hold register until S_DATA completes.
  - From S_DATA the FSM goes to the first state of the next beat if a beat is accepted the same cycle, else S_IDLE.
- AXIS rules: m_axis_tvalid never drops and m_axis_tdata never changes while stalled (m_axis_tready=0).
- Bypass changes take effect only at packet boundaries:
  - bypass_active samples bypass when in S_IDLE with no packet open, or on the cycle a tlast beat's final word is consumed.
  - Mid-packet toggles of bypass are ignored until the boundary.
  - "Packet open" is set on acceptance of a non-tlast beat and cleared on acceptance of a tlast beat.
- Reset mid-sequence discards the held beat and any partial escape sequence. The output restarts clean with no orphan ESCAPE.
- Counters wrap modulo 2^CWIDTH. Each increments once per input beat at acceptance.

Optional Feature:
- Macro: RWT_ESC_STATS_EN.
- Defined: stat_beats, stat_escapes and stat_tags count as above; counter registers are reset by resetn.
- Undefined: stat_* are tied to 0 and no counter flops are inferred.

Test Plan:
- Beats 1,2,3 (tuser=0, tlast on 3), m_axis_tready=1 -> out 1,2,3, tlast on 3, one word/cycle, first word 1 cycle after acceptance.
- Beat AAAAAAAA tuser=0 tlast=1 -> out AAAAAAAA, AAAAAAAA with tlast on the second only. stat_escapes=1.
- Beat 5 tuser=2'b11, then 6 tuser=0 tlast -> out AAAAAAAA, 00000003, 5, 6(tlast). stat_tags=1, stat_beats=2.
- Beat AAAAAAAA tuser=1 tlast, with m_axis_tready toggling 1,0,1,0 -> out AAAAAAAA, 00000001, AAAAAAAA, AAAAAAAA(tlast). Data stable during stalls; s_axis_tready low until the final word is consumed.
- bypass raised mid-packet (10,11,AAAAAAAA tlast) -> packet still escaped. Next packet AAAAAAAA tuser=1 tlast is passed raw as one word, tlast set; bypass_active rises at the boundary.
- resetn pulsed low while in S_TAG -> all outputs 0 immediately. After release, beat 7 -> out 7 only.
